// File: rtl/matmul_seq_ctrl_if.sv
// Bundle between the matrix-multiply sequencer, its requester and the
// external pipelined multiplier it time-shares.
interface matmul_seq_ctrl_if #(
   parameter int unsigned N     = 4,
   parameter int unsigned WIDTH = 16
);
   localparam int unsigned ACC_W = 2 * WIDTH + $clog2(N);

   logic                              start;
   logic                              ready;
   logic                              busy;
   logic                              done;
   logic [N-1:0][N-1:0][WIDTH-1:0]    A;
   logic [N-1:0][N-1:0][WIDTH-1:0]    B;
   logic [N-1:0][N-1:0][ACC_W-1:0]    C;
   logic [WIDTH-1:0]                  mul_a;
   logic [WIDTH-1:0]                  mul_b;
   logic [2*WIDTH-1:0]                mul_result;

   // Requester / multiplier side
   modport master (
      output start, A, B, mul_result,
      input  ready, busy, done, C, mul_a, mul_b
   );

   // Sequencer side
   modport slave (
      input  start, A, B, mul_result,
      output ready, busy, done, C, mul_a, mul_b
   );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// NxN matrix multiply C = A x B using one shared external pipelined
// multiplier. Operand pairs go out one per cycle (k innermost, then j, then i);
// a tag pipeline matched to the multiplier latency steers each returning
// product into the accumulator and, on the last k, into C[i][j].
module matmul_seq_ctrl #(
   parameter int unsigned N           = 4,
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned PIPE_STAGES = 10
) (
   input  logic             clk,
   input  logic             rst,
   matmul_seq_ctrl_if.slave bus
);
   localparam int unsigned ACC_W = 2 * WIDTH + $clog2(N);
   localparam int unsigned CW    = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_t;

   typedef struct packed {
      logic          vld;
      logic [CW-1:0] i;
      logic [CW-1:0] j;
      logic          first;
      logic          last;
   } tag_t;

   typedef logic [N-1:0][N-1:0][WIDTH-1:0] mat_t;
   typedef logic [N-1:0][N-1:0][ACC_W-1:0] cmat_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     i_q, i_d;
   logic [CW-1:0]     j_q, j_d;
   logic [CW-1:0]     k_q, k_d;
   mat_t              a_q, a_d;
   mat_t              b_q, b_d;
   tag_t              tag_q [PIPE_STAGES];
   tag_t              tag_d [PIPE_STAGES];
   logic [ACC_W-1:0]  acc_q, acc_d;
   cmat_t             c_q, c_d;
   logic [WIDTH-1:0]  mul_a_q, mul_a_d;
   logic [WIDTH-1:0]  mul_b_q, mul_b_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   tag_t              tag_in;
   tag_t              out_tag;
   logic [ACC_W-1:0]  prod_ext;
   logic [ACC_W-1:0]  sum;

   // Next-state, issue counters, tag shift, accumulate and registered outputs
   always_comb begin
      state_d  = state_q;
      i_d      = i_q;
      j_d      = j_q;
      k_d      = k_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      c_d      = c_q;
      tag_in   = '0;
      out_tag  = tag_q[PIPE_STAGES-1];
      prod_ext = ACC_W'(bus.mul_result);
      sum      = '0;
      mul_a_d  = '0;
      mul_b_d  = '0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               a_d     = bus.A;
               b_d     = bus.B;
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            tag_in.vld   = 1'b1;
            tag_in.i     = i_q;
            tag_in.j     = j_q;
            tag_in.first = (k_q == '0);
            tag_in.last  = (k_q == LAST_IDX);
            if (k_q == LAST_IDX) begin
               k_d = '0;
               if (j_q == LAST_IDX) begin
                  j_d = '0;
                  if (i_q == LAST_IDX) begin
                     i_d     = '0;
                     state_d = S_DRAIN;
                  end else begin
                     i_d = i_q + CW'(1);
                  end
               end else begin
                  j_d = j_q + CW'(1);
               end
            end else begin
               k_d = k_q + CW'(1);
            end
         end
         S_DRAIN: begin
            // The final element's last product marks the end of the run
            if (out_tag.vld && out_tag.last &&
                out_tag.i == LAST_IDX && out_tag.j == LAST_IDX) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      tag_d[0] = tag_in;
      for (int s = 1; s < PIPE_STAGES; s++) begin
         tag_d[s] = tag_q[s-1];
      end

      sum = out_tag.first ? prod_ext : acc_q + prod_ext;
      if (out_tag.vld) begin
         acc_d = sum;
         if (out_tag.last) begin
            c_d[out_tag.i][out_tag.j] = sum;
         end
      end

      // Operands are registered from next-cycle counters so they appear in
      // the same cycle the counters address them
      if (state_d == S_ISSUE) begin
         mul_a_d = a_d[i_d][k_d];
         mul_b_d = b_d[k_d][j_d];
      end
      ready_d = (state_d == S_IDLE);
      busy_d  = (state_d == S_ISSUE) || (state_d == S_DRAIN);
      done_d  = (state_d == S_DONE);
   end

   // State and datapath registers; reset aborts any run and clears C
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         c_q     <= '0;
         mul_a_q <= '0;
         mul_b_q <= '0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         for (int s = 0; s < PIPE_STAGES; s++) begin
            tag_q[s] <= '0;
         end
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         c_q     <= c_d;
         mul_a_q <= mul_a_d;
         mul_b_q <= mul_b_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         for (int s = 0; s < PIPE_STAGES; s++) begin
            tag_q[s] <= tag_d[s];
         end
      end
   end

   assign bus.ready = ready_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.C     = c_q;
   assign bus.mul_a = mul_a_q;
   assign bus.mul_b = mul_b_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Scoreboard bench for matmul_seq_ctrl: a reference process predicts each
// accepted run (result matrix and done cycle) and the cycle-level timeline;
// a monitor compares DUT outputs on the falling edge.
module tb_matmul_seq_ctrl;
   localparam int unsigned N     = 4;
   localparam int unsigned WIDTH = 16;
   localparam int unsigned P     = 10;
   localparam int unsigned ACC_W = 2 * WIDTH + $clog2(N);
   localparam int          NCUBE = N * N * N;
   localparam int          L     = NCUBE + P;

   typedef logic [N-1:0][N-1:0][WIDTH-1:0] mat_t;
   typedef logic [N-1:0][N-1:0][ACC_W-1:0] cmat_t;
   typedef struct {
      cmat_t cm;
      int    done_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   matmul_seq_ctrl_if #(.N(N), .WIDTH(WIDTH)) bus ();

   matmul_seq_ctrl #(.N(N), .WIDTH(WIDTH), .PIPE_STAGES(P)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // External multiplier: P-cycle latency
   logic [2*WIDTH-1:0] mpipe [P];
   always @(posedge clk) begin
      mpipe[0] <= (2*WIDTH)'(bus.mul_a) * (2*WIDTH)'(bus.mul_b);
      for (int s = 1; s < P; s++) mpipe[s] <= mpipe[s-1];
   end
   assign bus.mul_result = mpipe[P-1];

   int    checks = 0;
   int    fails  = 0;
   int    cyc    = 0;
   bit    run_act = 1'b0;
   int    run_s   = 0;
   mat_t  snap_a, snap_b;
   cmat_t model_c = '0;
   cmat_t run_c;
   exp_t  sbq [$];

   function automatic cmat_t ref_mm(input mat_t a, input mat_t b);
      cmat_t r;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            longint unsigned acc = 0;
            for (int k = 0; k < N; k++) acc += 64'(a[i][k]) * 64'(b[k][j]);
            r[i][j] = ACC_W'(acc);
         end
      return r;
   endfunction

   function automatic mat_t rand_mat();
      mat_t m;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) m[i][j] = WIDTH'($urandom);
      return m;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic cmp_mat(input string name, input cmat_t act, input cmat_t exp);
      int bi, bj;
      bit bad;
      bad = 1'b0; bi = 0; bj = 0;
      checks++;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            if (!bad && act[i][j] !== exp[i][j]) begin
               bad = 1'b1; bi = i; bj = j;
            end
      if (bad) begin
         fails++;
         $display("FAIL %s cycle=%0d C[%0d][%0d] got=0x%0h expected=0x%0h",
                  name, cyc, bi, bj, act[bi][bj], exp[bi][bj]);
      end
   endtask

   // Reference: acceptance, abort and retirement decided from inputs alone
   always @(posedge clk) begin : ref_model
      int cnow;
      cnow = cyc;
      if (rst) begin
         run_act = 1'b0;
         model_c = '0;
         sbq.delete();
      end else if (!run_act && bus.start) begin
         run_act = 1'b1;
         run_s   = cnow;
         snap_a  = bus.A;
         snap_b  = bus.B;
         run_c   = ref_mm(bus.A, bus.B);
         sbq.push_back('{cm: run_c, done_cyc: cnow + L + 1});
      end else if (run_act && (cnow - run_s) == L + 1) begin
         run_act = 1'b0;
         model_c = run_c;
      end
      cyc = cyc + 1;
   end

   // Monitor: timeline checks every cycle, scoreboard pop on each done
   always @(negedge clk) begin : monitor
      int d, idx, mi, mj, mk;
      logic [WIDTH-1:0] ea, eb;
      bit eready, ebusy, edone;
      exp_t it;
      if (cyc >= 1) begin
         eready = 1'b1; ebusy = 1'b0; edone = 1'b0; ea = '0; eb = '0;
         if (run_act) begin
            d      = cyc - run_s;
            eready = 1'b0;
            ebusy  = (d <= L);
            edone  = (d == L + 1);
            if (d >= 1 && d <= NCUBE) begin
               idx = d - 1;
               mk  = idx % N;
               mj  = (idx / N) % N;
               mi  = idx / (N * N);
               ea  = snap_a[mi][mk];
               eb  = snap_b[mk][mj];
            end
         end else begin
            cmp_mat("c_hold", bus.C, model_c);
         end
         check("ready", 64'(bus.ready), 64'(eready));
         check("busy", 64'(bus.busy), 64'(ebusy));
         check("done", 64'(bus.done), 64'(edone));
         check("mul_a", 64'(bus.mul_a), 64'(ea));
         check("mul_b", 64'(bus.mul_b), 64'(eb));
         if (bus.done) begin
            if (sbq.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL done_unexpected cycle=%0d got done=1 expected no pending result", cyc);
            end else begin
               it = sbq.pop_front();
               check("done_cycle", 64'(cyc), 64'(it.done_cyc));
               cmp_mat("c_result", bus.C, it.cm);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input mat_t a, input mat_t b, output int s);
      bus.A     = a;
      bus.B     = b;
      bus.start = 1'b1;
      s         = cyc;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!bus.done && n < L + 20) begin
         tick();
         n++;
      end
      if (!bus.done) begin
         checks++;
         fails++;
         $display("FAIL %s_timeout cycle=%0d got no done within %0d cycles expected done", name, cyc, n);
      end
      tick();
   endtask

   initial begin : stim
      mat_t a, b;
      int s;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // A[i][j] = i+j times identity
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            a[i][j] = WIDTH'(i + j);
            b[i][j] = (i == j) ? WIDTH'(1) : WIDTH'(0);
         end
      pulse_start(a, b, s);
      wait_done("identity");
      repeat (2) tick();

      // Full-scale operands: no truncation of the accumulated sum
      a = '1;
      b = '1;
      pulse_start(a, b, s);
      wait_done("all_ones");
      repeat (2) tick();

      // Extra start pulses while busy and in the done cycle are ignored
      pulse_start(rand_mat(), rand_mat(), s);
      while (cyc < s + 5) tick();
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      while (cyc < s + 75) tick();
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      repeat (4) tick();

      // Inputs scrambled every cycle after acceptance
      pulse_start(rand_mat(), rand_mat(), s);
      repeat (80) begin
         bus.A = rand_mat();
         bus.B = rand_mat();
         tick();
      end
      repeat (2) tick();

      // Reset mid-run (with start high at the same time), then a clean run
      pulse_start(rand_mat(), rand_mat(), s);
      while (cyc < s + 30) tick();
      rst = 1'b1; bus.start = 1'b1;
      tick();
      rst = 1'b0; bus.start = 1'b0;
      repeat (3) tick();
      pulse_start(rand_mat(), rand_mat(), s);
      wait_done("after_reset");
      repeat (2) tick();

      // Start held high: back-to-back runs
      bus.A = rand_mat();
      bus.B = rand_mat();
      bus.start = 1'b1;
      repeat (200) tick();
      bus.start = 1'b0;
      wait_done("back_to_back");
      repeat (2) tick();

      // A few more random runs
      repeat (3) begin
         pulse_start(rand_mat(), rand_mat(), s);
         wait_done("random");
         tick();
      end

      check("scoreboard_empty", 64'(sbq.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog cycle=%0d got no completion expected finish", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
- Sequencer that computes C = A x B (NxN) by time-sharing one external pipelined multiplier, instead of instantiating N^3 multipliers.
- Snapshots A and B on start, issues one A[i][k]*B[k][j] operand pair per cycle, and tracks each in-flight product with a tag pipeline matched to the multiplier latency.
- Accumulates the returned products into the C registers and pulses done when the last element is written.

Parameters:
- N, 4, matrix dimension (NxN), N >= 1
- WIDTH, 16, operand bit-width
- PIPE_STAGES, 10, latency of the external multiplier in cycles, >= 1
- ACC_W, 2*WIDTH+$clog2(N), accumulator and C element width (derived, not overridden)

Ports:
- clk  input  1  single clock, all state on posedge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new multiply; accepted only while ready=1
- ready  output  1  high in IDLE
- busy  output  1  high from the first issue cycle through the last write-back cycle
- done  output  1  one-cycle pulse after the last C element is written
- A  input  [WIDTH-1:0] x N x N  left operand; sampled only on start acceptance
- B  input  [WIDTH-1:0] x N x N  right operand; sampled only on start acceptance
- C  output  [ACC_W-1:0] x N x N  result registers
- mul_a  output  WIDTH  operand to external multiplier
- mul_b  output  WIDTH  operand to external multiplier
- mul_result  input  2*WIDTH  multiplier output, valid PIPE_STAGES cycles after its operands

Behaviour:
- Reset: state=IDLE, ready=1, busy=0, done=0, all C=0, tag pipeline cleared, counters i/j/k=0, mul_a=mul_b=0. Reset mid-operation aborts immediately: no done pulse, in-flight products are discarded, and C is cleared.
- States:
  - IDLE: start=1 snapshots A and B into A_q and B_q, clears counters, and moves to ISSUE. Inputs A and B are don't-care afterwards.
  - ISSUE: drives mul_a=A_q[i][k] and mul_b=B_q[k][j] combinationally from the counters. Order is k innermost, then j, then i. Issues exactly N^3 pairs, one per cycle. After issuing (N-1,N-1,N-1) it moves to DRAIN.
  - DRAIN: waits until the last tag exits the tag pipeline, then moves to DONE.
  - DONE: done=1 for exactly this one cycle, start is ignored, next state is IDLE.
- Outside ISSUE, mul_a and mul_b are 0.
- Tag pipeline:
  - PIPE_STAGES-deep shift register of {valid, i, j, first=(k==0), last=(k==N-1)}, loaded in each issue cycle.
  - The tag at the output aligns with mul_result. An operand pair issued in cycle t returns in cycle t+PIPE_STAGES.
- Accumulate (on a valid output tag):
  - acc <= first ? zero-extended mul_result : acc + mul_result.
  - When last, C[i][j] <= final sum (acc + mul_result, or mul_result alone if N=1).
  - The sum never overflows ACC_W.
- C behaviour:
  - Elements update one at a time during a run. Each holds its previous value until rewritten.
  - C is valid as a whole from the done cycle until the next start acceptance.
- Timing: start accepted in cycle 0; issues occupy cycles 1..N^3; the last product returns in cycle N^3+PIPE_STAGES; done is high in cycle N^3+PIPE_STAGES+1. For N=4, PIPE_STAGES=10: done in cycle 75.
- busy=1 in cycles 1..N^3+PIPE_STAGES.
- Boundary conditions:
  - start while busy or in DONE is ignored, with no side effects.
  - start held high continuously gives back-to-back runs: the next acceptance is in the IDLE cycle right after DONE.
  - rst and start asserted together: rst wins.
  - N=1 gives a single issue with first=last=1.

Test Plan:
- A[i][j]=i+j, B=identity, N=4, P=10, start at cycle 0 -> C[i][j]=i+j; done high only in cycle 75; busy high in cycles 1..74; ready=0 in cycles 1..75.
- All A and B elements = 16'hFFFF -> every C element = 34'h3_FFF8_0004, with no truncation.
- Start pulsed again at cycles 5 and 75 -> both ignored; exactly one done pulse; C unchanged by the extra pulses.
- A and B randomised every cycle after start acceptance -> C equals the product of the snapshot taken at acceptance, per the reference model.
- rst asserted at cycle 30 of a run -> next cycle: C=0, busy=0, ready=1, no done pulse. A new start then completes correctly 75 cycles later.
- start held high for 200 cycles with constant random A and B -> done pulses in cycles 75 and 151; both results match the reference model.
